// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multicycle and single-cycle cores:
// FSM state codes, opcodes, ALU control and datapath mux select values.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_BAD = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode shared by the single-cycle and multicycle cores.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_BAD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, which never subtracts
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_BAD;
        endcase
      end
      default: alu_control = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the shared multicycle datapath, plus
// ImmSrc decode and the shared ALU decoder.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state
);

  state_t     state_r, state_n;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_n;
  end

  always_comb begin
    state_n   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    aluop     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        state_n   = S_DECODE;
        ir_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTER;
          OP_ITYPE:     state_n = S_EXECUTEI;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_n   = S_ALUWB;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Enables are gated by reset so an aborted instruction commits nothing
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign MemWrite = ~reset & mem_write;
  assign state    = state_r;

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .state      (state)
  );

  // {PCWrite, IRWrite, RegWrite, MemWrite}
  function automatic logic [7:0] en();
    return {4'b0, PCWrite, IRWrite, RegWrite, MemWrite};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one R/I-type instruction from FETCH back to FETCH
  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] exec_st, input logic [2:0] exp_alu);
    op = o; funct3 = f3; funct7b5 = f7;
    tick(); chk({tag, "_decode"}, 8'(state), 8'd1);
    tick(); chk({tag, "_exec_st"}, 8'(state), 8'(exec_st));
    chk({tag, "_aluctl"}, 8'(ALUControl), 8'(exp_alu));
    chk({tag, "_srca"}, 8'(ALUSrcA), 8'h2);
    tick(); chk({tag, "_wb"}, en(), 8'b0010);
    tick(); chk({tag, "_fetch"}, 8'(state), 8'd0);
  endtask

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    tick(); tick(); tick();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_en", en(), 8'b0000);
    reset = 1'b0;
    #1;
    chk("rel_state", 8'(state), 8'd0);
    chk("rel_en", en(), 8'b1100);
    chk("rel_srcb", 8'(ALUSrcB), 8'h2);
    chk("rel_res", 8'(ResultSrc), 8'h2);

    // lw
    tick(); chk("lw_s1", 8'(state), 8'd1);
    chk("lw_dec_srca", 8'(ALUSrcA), 8'h1);
    chk("lw_dec_srcb", 8'(ALUSrcB), 8'h1);
    chk("lw_imm", 8'(ImmSrc), 8'h0);
    tick(); chk("lw_s2", 8'(state), 8'd2);
    chk("lw_adr_srca", 8'(ALUSrcA), 8'h2);
    chk("lw_adr_en", en(), 8'b0000);
    tick(); chk("lw_s3", 8'(state), 8'd3);
    chk("lw_adrsrc", 8'(AdrSrc), 8'h1);
    chk("lw_rd_en", en(), 8'b0000);
    tick(); chk("lw_s4", 8'(state), 8'd4);
    chk("lw_wb_en", en(), 8'b0010);
    chk("lw_wb_res", 8'(ResultSrc), 8'h1);
    tick(); chk("lw_s0", 8'(state), 8'd0);

    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001);
    run_alu("add",  7'b0110011, 3'b000, 1'b0, 4'd6, 3'b000);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, 4'd7, 3'b000);
    run_alu("or",   7'b0110011, 3'b110, 1'b0, 4'd6, 3'b011);
    run_alu("slt",  7'b0110011, 3'b010, 1'b0, 4'd6, 3'b101);
    run_alu("and",  7'b0110011, 3'b111, 1'b0, 4'd6, 3'b010);
    run_alu("badf3", 7'b0110011, 3'b001, 1'b0, 4'd6, 3'b111);

    // beq taken
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    tick(); chk("beqt_imm", 8'(ImmSrc), 8'h2);
    tick(); chk("beqt_s9", 8'(state), 8'd9);
    chk("beqt_pcw", 8'(PCWrite), 8'h1);
    chk("beqt_alu", 8'(ALUControl), 8'h1);
    tick(); chk("beqt_s0", 8'(state), 8'd0);
    // beq not taken
    Zero = 1'b0;
    tick(); tick(); chk("beqn_s9", 8'(state), 8'd9);
    chk("beqn_en", en(), 8'b0000);
    tick(); chk("beqn_s0", 8'(state), 8'd0);

    // jal
    op = 7'b1101111;
    tick(); chk("jal_s1", 8'(state), 8'd1);
    chk("jal_imm", 8'(ImmSrc), 8'h3);
    tick(); chk("jal_s10", 8'(state), 8'd10);
    chk("jal_en", en(), 8'b1000);
    chk("jal_srca", 8'(ALUSrcA), 8'h1);
    chk("jal_srcb", 8'(ALUSrcB), 8'h2);
    tick(); chk("jal_s8", 8'(state), 8'd8);
    chk("jal_wb_en", en(), 8'b0010);
    tick(); chk("jal_s0", 8'(state), 8'd0);

    // illegal op acts as nop
    op = 7'b0000000;
    tick(); chk("nop_s1", 8'(state), 8'd1);
    chk("nop_en", en(), 8'b0000);
    tick(); chk("nop_s0", 8'(state), 8'd0);

    // sw aborted by reset in MEMWRITE
    op = 7'b0100011;
    tick(); chk("sw_imm", 8'(ImmSrc), 8'h1);
    tick(); chk("sw_s2", 8'(state), 8'd2);
    tick(); chk("sw_s5", 8'(state), 8'd5);
    chk("sw_memw", en(), 8'b0001);
    reset = 1'b1;
    #1;
    chk("sw_rst_en", en(), 8'b0000);
    chk("sw_rst_adr", 8'(AdrSrc), 8'h1);
    tick(); chk("sw_rst_s0", 8'(state), 8'd0);
    chk("sw_rst_fetch_en", en(), 8'b0000);
    reset = 1'b0;
    #1;
    chk("sw_rel_en", en(), 8'b1100);
    tick(); chk("sw_rel_s1", 8'(state), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
